fetch_queue: RTL

Instruction fetch queue directly downstream of the fetch stage. Pairs each fetched `pc` with the instruction word returned by the synchronous instruction memory, buffers the pairs in a small circular FIFO and presents them to decode over a valid/ready handshake. Back-pressures fetch through its `halt` input and discards wrong-path words when fetch reports a taken branch.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue_mem.sv | 32 +++
 rtl/fetch_queue.sv | 118 +++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared widths, default depth and the queue entry layout for the fetch queue.
package fetch_queue_pkg;

  localparam int XLEN     = 32;
  localparam int ILEN     = 32;
  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/memory/decode signal bundle; the queue connects through the slave modport.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            fetch_taken_branch;
  logic [ILEN-1:0] imem_rdata;
  logic            fetch_halt;
  logic            dec_valid;
  logic            dec_ready;
  logic [ILEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [CW-1:0]   fq_count;

  modport master (
    output fetch_pc, fetch_taken_branch, imem_rdata, dec_ready,
    input  fetch_halt, dec_valid, dec_instr, dec_pc, fq_count
  );

  modport slave (
    input  fetch_pc, fetch_taken_branch, imem_rdata, dec_ready,
    output fetch_halt, dec_valid, dec_instr, dec_pc, fq_count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Queue storage: DEPTH entries of {instr, pc}, one write port, combinational read.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem_r [DEPTH];

  // Entry array write, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: pairs fetch pcs with imem words and feeds decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic            req_q;
  logic [XLEN-1:0] req_pc_q;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  logic      flush_s;
  logic      push_s;
  logic      write_s;
  logic      pop_mem_s;
  logic      halt_s;
  logic      valid_s;
  logic [CW:0] occ_s;
  fq_entry_t resp_s;
  fq_entry_t head_s;
  fq_entry_t out_s;

  assign flush_s = bus.fetch_taken_branch;
  assign push_s  = req_q & ~flush_s;
  assign resp_s  = '{instr: bus.imem_rdata, pc: req_pc_q};
  // Queued entries plus the response still in flight must always fit.
  assign occ_s   = {1'b0, count_r} + {{CW{1'b0}}, req_q};

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (write_s),
    .waddr (wr_ptr_r),
    .wdata (resp_s),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  // Halt, head presentation, and the write/pop decisions for this cycle
  always_comb begin
    halt_s    = 1'b0;
    valid_s   = 1'b0;
    out_s     = '0;
    write_s   = push_s;
    pop_mem_s = 1'b0;
    if ((occ_s >= DEPTH_W) && !flush_s) begin
      halt_s = 1'b1;
    end else begin
      halt_s = 1'b0;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((count_r == '0) && push_s) begin
      valid_s = 1'b1;
      out_s   = resp_s;
      write_s = ~bus.dec_ready;
    end else if ((count_r != '0) && !flush_s) begin
      valid_s   = 1'b1;
      out_s     = head_s;
      pop_mem_s = bus.dec_ready;
    end else begin
      valid_s = 1'b0;
      out_s   = '0;
    end
`else
    if ((count_r != '0) && !flush_s) begin
      valid_s   = 1'b1;
      out_s     = head_s;
      pop_mem_s = bus.dec_ready;
    end else begin
      valid_s = 1'b0;
      out_s   = '0;
    end
`endif
  end

  // Request tracking, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= 1'b0;
      req_pc_q <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      req_q    <= ~halt_s;
      req_pc_q <= halt_s ? req_pc_q : bus.fetch_pc;
      if (flush_s) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        rd_ptr_r <= pop_mem_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        wr_ptr_r <= write_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        count_r  <= count_r + (write_s ? CNT_ONE : '0) - (pop_mem_s ? CNT_ONE : '0);
      end
    end
  end

  assign bus.fetch_halt = halt_s;
  assign bus.dec_valid  = valid_s;
  assign bus.dec_instr  = out_s.instr;
  assign bus.dec_pc     = out_s.pc;
  assign bus.fq_count   = count_r;

endmodule
